// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: one instruction-fetch port and one data port share a
// single memory request channel. Data requests win ties. Each transaction is
// latched at grant, completes on a one-cycle memory ready strobe (or aborts on
// a wait-counter timeout), and finishes with a single done pulse to its owner.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction; grants DM first, then IC
// IC_BUSY | fetch in flight, waiting for i_MEM_ready
// DM_BUSY | load/store in flight, waiting for i_MEM_ready
// RESP    | one-cycle done pulse to the owning side; never grants here

`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int XLEN    = `XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IC_Addr,
  output logic [XLEN-1:0] o_IC_Instr,
  output logic            o_IC_MemReady,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [2:0]      i_DM_f3,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wd,
  output logic [2:0]      o_MEM_f3,
  output logic            o_MEM_wen,
  output logic            o_MEM_ren,
  input  logic [XLEN-1:0] i_MEM_rdata,
  input  logic            i_MEM_ready,
  output logic            o_bus_err
);

  localparam int            CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC     = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, IC_BUSY, DM_BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic            busy, mem_done, timeout_hit, grant_dm, grant_ic;
  logic [CW-1:0]   wait_cnt;
  logic            resp_dm;
  logic [XLEN-1:0] addr_q, wd_q, ic_instr_q, dm_rdata_q;
  logic [2:0]      f3_q;
  logic            wen_q, ren_q, bus_err_q;

  // Next-state decode; completion is checked before the timeout so a ready
  // strobe on the last allowed cycle still completes normally.
  always_comb begin
    state_nxt   = state;
    grant_dm    = 1'b0;
    grant_ic    = 1'b0;
    busy        = (state == IC_BUSY) || (state == DM_BUSY);
    mem_done    = busy && i_MEM_ready;
    timeout_hit = TO_EN && busy && !i_MEM_ready && (wait_cnt == TC);
    case (state)
      IDLE: begin
        if (i_DM_Wen || i_DM_MemRead) begin
          grant_dm  = 1'b1;
          state_nxt = DM_BUSY;
        end else if (i_IC_DataReq) begin
          grant_ic  = 1'b1;
          state_nxt = IC_BUSY;
        end
      end
      IC_BUSY, DM_BUSY: begin
        if (mem_done)         state_nxt = RESP;
        else if (timeout_hit) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the granted request; these registers alone drive the memory bus,
  // so requester churn during a transaction cannot reach it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= 3'b000;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      resp_dm <= 1'b0;
    end else if (grant_dm) begin
      addr_q  <= i_DM_Addr;
      wd_q    <= i_DM_Wd;
      f3_q    <= i_DM_f3;
      wen_q   <= i_DM_Wen;
      ren_q   <= i_DM_MemRead;
      resp_dm <= 1'b1;
    end else if (grant_ic) begin
      addr_q  <= i_IC_Addr;
      wd_q    <= '0;
      f3_q    <= 3'b010;
      wen_q   <= 1'b0;
      ren_q   <= 1'b1;
      resp_dm <= 1'b0;
    end
  end

  // Wait counter: cleared at grant, counts busy cycles with no ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst)                    wait_cnt <= '0;
    else if (grant_dm || grant_ic) wait_cnt <= '0;
    else if (busy && !i_MEM_ready) wait_cnt <= wait_cnt + 1'b1;
  end

  // Read data capture; stores leave the load-data register untouched.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ic_instr_q <= '0;
      dm_rdata_q <= '0;
    end else if (mem_done) begin
      if (state == IC_BUSY)        ic_instr_q <= i_MEM_rdata;
      else if (ren_q)              dm_rdata_q <= i_MEM_rdata;
    end
  end

  // Abort pulse lands in the first IDLE cycle after the timeout.
  always_ff @(posedge i_clk) begin
    if (!i_rst) bus_err_q <= 1'b0;
    else        bus_err_q <= timeout_hit;
  end

  assign o_MEM_addr      = addr_q;
  assign o_MEM_wd        = wd_q;
  assign o_MEM_f3        = f3_q;
  assign o_MEM_wen       = wen_q & busy;
  assign o_MEM_ren       = ren_q & busy;
  assign o_IC_Instr      = ic_instr_q;
  assign o_DM_ReadData   = dm_rdata_q;
  assign o_IC_MemReady   = (state == RESP) && !resp_dm;
  assign o_DM_data_ready = (state == RESP) && resp_dm;
  assign o_bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference (one outstanding
// request record, held read data, pending done/abort pulses) checked against
// the DUT every cycle, plus literal expectations in each directed scenario.

module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_IC_DataReq;
  logic [31:0] i_IC_Addr;
  logic [31:0] o_IC_Instr;
  logic        o_IC_MemReady;
  logic [31:0] i_DM_Addr, i_DM_Wd;
  logic [2:0]  i_DM_f3;
  logic        i_DM_Wen, i_DM_MemRead;
  logic [31:0] o_DM_ReadData;
  logic        o_DM_data_ready;
  logic [31:0] o_MEM_addr, o_MEM_wd;
  logic [2:0]  o_MEM_f3;
  logic        o_MEM_wen, o_MEM_ren;
  logic [31:0] i_MEM_rdata;
  logic        i_MEM_ready;
  logic        o_bus_err;

  mem_arbiter #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_IC_DataReq(i_IC_DataReq), .i_IC_Addr(i_IC_Addr),
    .o_IC_Instr(o_IC_Instr), .o_IC_MemReady(o_IC_MemReady),
    .i_DM_Addr(i_DM_Addr), .i_DM_Wd(i_DM_Wd), .i_DM_f3(i_DM_f3),
    .i_DM_Wen(i_DM_Wen), .i_DM_MemRead(i_DM_MemRead),
    .o_DM_ReadData(o_DM_ReadData), .o_DM_data_ready(o_DM_data_ready),
    .o_MEM_addr(o_MEM_addr), .o_MEM_wd(o_MEM_wd), .o_MEM_f3(o_MEM_f3),
    .o_MEM_wen(o_MEM_wen), .o_MEM_ren(o_MEM_ren),
    .i_MEM_rdata(i_MEM_rdata), .i_MEM_ready(i_MEM_ready),
    .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit started  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: one outstanding transaction, a one-cycle gap after every
  // completion, data held per side, abort after TMO unanswered busy cycles.
  bit          m_act, m_dm, m_wen, m_ren;
  logic [31:0] m_addr, m_wd, m_instr, m_rdata;
  logic [2:0]  m_f3;
  int          m_wait;
  bit          m_pulse_ic, m_pulse_dm, m_err, m_gap;

  always @(posedge i_clk) begin
    cyc++;
    started = 1;
    m_gap      = m_pulse_ic | m_pulse_dm;
    m_pulse_ic = 0;
    m_pulse_dm = 0;
    m_err      = 0;
    if (!i_rst) begin
      m_act = 0; m_dm = 0; m_wen = 0; m_ren = 0;
      m_addr = '0; m_wd = '0; m_f3 = '0; m_instr = '0; m_rdata = '0;
      m_wait = 0;
    end else if (m_act) begin
      if (i_MEM_ready) begin
        if (m_dm) begin
          m_pulse_dm = 1;
          if (m_ren) m_rdata = i_MEM_rdata;
        end else begin
          m_pulse_ic = 1;
          m_instr    = i_MEM_rdata;
        end
        m_act = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_err = 1;
          m_act = 0;
        end
      end
    end else if (!m_gap) begin
      if (i_DM_Wen || i_DM_MemRead) begin
        m_act = 1; m_dm = 1; m_wait = 0;
        m_addr = i_DM_Addr; m_wd = i_DM_Wd; m_f3 = i_DM_f3;
        m_wen = i_DM_Wen; m_ren = i_DM_MemRead;
      end else if (i_IC_DataReq) begin
        m_act = 1; m_dm = 0; m_wait = 0;
        m_addr = i_IC_Addr; m_wd = '0; m_f3 = 3'b010;
        m_wen = 0; m_ren = 1;
      end
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge i_clk) begin
    if (started) begin
      chk("mem_ren",  {31'b0, o_MEM_ren},       {31'b0, m_act & m_ren});
      chk("mem_wen",  {31'b0, o_MEM_wen},       {31'b0, m_act & m_wen});
      chk("mem_addr", o_MEM_addr,               m_addr);
      chk("mem_wd",   o_MEM_wd,                 m_wd);
      chk("mem_f3",   {29'b0, o_MEM_f3},        {29'b0, m_f3});
      chk("ic_ready", {31'b0, o_IC_MemReady},   {31'b0, m_pulse_ic});
      chk("dm_ready", {31'b0, o_DM_data_ready}, {31'b0, m_pulse_dm});
      chk("ic_instr", o_IC_Instr,               m_instr);
      chk("dm_rdata", o_DM_ReadData,            m_rdata);
      chk("bus_err",  {31'b0, o_bus_err},       {31'b0, m_err});
    end
  end

  // Wait (at negedges) until the memory bus carries a request; returns cycle.
  task automatic wait_bus(input string nm, output int at);
    int t = 0;
    at = -1;
    while (!(o_MEM_ren || o_MEM_wen)) begin
      @(negedge i_clk);
      t++;
      if (t > 40) begin
        n_checks++; n_err++;
        $display("FAIL %s: bus request never seen, got none expected one", nm);
        return;
      end
    end
    at = cyc;
  endtask

  // Wait for a pulse: sel 0 = IC ready, 1 = DM ready, 2 = bus error.
  task automatic wait_pulse(input string nm, input int sel, output int at);
    int t = 0;
    at = -1;
    forever begin
      if ((sel == 0 && o_IC_MemReady) || (sel == 1 && o_DM_data_ready) ||
          (sel == 2 && o_bus_err)) begin
        at = cyc;
        return;
      end
      @(negedge i_clk);
      t++;
      if (t > 40) begin
        n_checks++; n_err++;
        $display("FAIL %s: pulse never seen, got none expected one", nm);
        return;
      end
    end
  endtask

  // Drive a one-cycle ready strobe 'lat' cycles after the current busy cycle.
  task automatic mem_respond(input int lat, input logic [31:0] data);
    repeat (lat) @(negedge i_clk);
    i_MEM_ready = 1'b1;
    i_MEM_rdata = data;
    @(negedge i_clk);
    i_MEM_ready = 1'b0;
    i_MEM_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  int b, b2, p, e;

  initial begin
    i_rst = 1'b0;
    i_IC_DataReq = 0; i_IC_Addr = '0;
    i_DM_Addr = '0; i_DM_Wd = '0; i_DM_f3 = '0; i_DM_Wen = 0; i_DM_MemRead = 0;
    i_MEM_rdata = '0; i_MEM_ready = 0;
    repeat (3) @(negedge i_clk);
    chk("rst_addr",  o_MEM_addr, 32'h0);
    chk("rst_ren",   {31'b0, o_MEM_ren}, 32'h0);
    chk("rst_instr", o_IC_Instr, 32'h0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // IC-only fetch, ready three cycles after the read is presented; the
    // strobe lands on the last busy cycle before the timeout would fire.
    i_IC_DataReq = 1; i_IC_Addr = 32'h100;
    wait_bus("ic_fetch", b);
    chk("ic_addr", o_MEM_addr, 32'h100);
    chk("ic_f3",   {29'b0, o_MEM_f3}, 32'h2);
    mem_respond(3, 32'h0050_0093);
    wait_pulse("ic_fetch", 0, p);
    chk("ic_lat",   p - b, 4);
    chk("ic_data",  o_IC_Instr, 32'h0050_0093);
    i_IC_DataReq = 0;
    @(negedge i_clk);
    chk("ic_pulse_one", {31'b0, o_IC_MemReady}, 32'h0);

    // Collision: DM load wins, IC is granted from IDLE afterwards.
    i_IC_DataReq = 1; i_IC_Addr = 32'h104;
    i_DM_MemRead = 1; i_DM_Addr = 32'h2000; i_DM_f3 = 3'b010;
    wait_bus("col_dm", b);
    chk("col_first", o_MEM_addr, 32'h2000);
    mem_respond(0, 32'h1122_3344);
    wait_pulse("col_dm", 1, p);
    chk("col_dm_lat", p - b, 1);
    chk("col_ic_not", {31'b0, o_IC_MemReady}, 32'h0);
    chk("col_dm_data", o_DM_ReadData, 32'h1122_3344);
    i_DM_MemRead = 0;
    @(negedge i_clk);
    wait_bus("col_ic", b2);
    chk("col_second", o_MEM_addr, 32'h104);
    chk("col_gap", b2 - b, 3);
    mem_respond(1, 32'h0000_0013);
    wait_pulse("col_ic", 0, p);
    chk("col_ic_data", o_IC_Instr, 32'h0000_0013);
    i_IC_DataReq = 0;
    @(negedge i_clk);

    // Store: bus carries it, load data stays put.
    i_DM_Wen = 1; i_DM_Addr = 32'h3004; i_DM_Wd = 32'hDEAD_BEEF; i_DM_f3 = 3'b000;
    wait_bus("store", b);
    chk("st_wen",  {31'b0, o_MEM_wen}, 32'h1);
    chk("st_wd",   o_MEM_wd, 32'hDEAD_BEEF);
    chk("st_addr", o_MEM_addr, 32'h3004);
    mem_respond(1, 32'hBAD0_BAD0);
    wait_pulse("store", 1, p);
    chk("st_rdata_hold", o_DM_ReadData, 32'h1122_3344);
    i_DM_Wen = 0;
    @(negedge i_clk);

    // Churn and mid-transaction drop: bus holds the granted load.
    i_DM_MemRead = 1; i_DM_Addr = 32'h4000; i_DM_f3 = 3'b100;
    wait_bus("churn", b);
    i_DM_Addr = 32'h5555_0000; i_DM_f3 = 3'b001; i_DM_Wd = 32'h1;
    @(negedge i_clk);
    chk("churn_addr", o_MEM_addr, 32'h4000);
    i_DM_MemRead = 0; i_DM_Addr = 32'h6666_0000;
    mem_respond(1, 32'hCAFE_F00D);
    wait_pulse("churn", 1, p);
    chk("churn_data", o_DM_ReadData, 32'hCAFE_F00D);
    @(negedge i_clk);

    // Timeout: no ready ever; abort after four busy cycles.
    i_IC_DataReq = 1; i_IC_Addr = 32'h200;
    wait_bus("tmo", b);
    i_IC_DataReq = 0;
    wait_pulse("tmo", 2, e);
    chk("tmo_lat",   e - b, 4);
    chk("tmo_idle",  {31'b0, o_MEM_ren}, 32'h0);
    chk("tmo_noack", {31'b0, o_IC_MemReady}, 32'h0);
    chk("tmo_instr", o_IC_Instr, 32'h0000_0013);
    repeat (2) @(negedge i_clk);

    // Reset mid DM_BUSY with a coincident ready strobe.
    i_DM_MemRead = 1; i_DM_Addr = 32'h7000;
    wait_bus("rst_mid", b);
    @(negedge i_clk);
    i_rst = 0; i_MEM_ready = 1; i_MEM_rdata = 32'h7777_7777;
    @(negedge i_clk);
    i_rst = 1; i_MEM_ready = 0; i_MEM_rdata = '0; i_DM_MemRead = 0;
    chk("rm_ren",    {31'b0, o_MEM_ren}, 32'h0);
    chk("rm_addr",   o_MEM_addr, 32'h0);
    chk("rm_dmrdy",  {31'b0, o_DM_data_ready}, 32'h0);
    chk("rm_rdata",  o_DM_ReadData, 32'h0);
    chk("rm_instr",  o_IC_Instr, 32'h0);
    repeat (3) @(negedge i_clk);
    chk("rm_quiet",  {31'b0, o_DM_data_ready}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
